// File: rtl/display_pkg.sv
// Shared definitions for the HEX message display path: message IDs and arbiter states.
package display_pkg;

    localparam int MSG_W = 4;

    localparam logic [MSG_W-1:0] MSG_IDLE       = 4'd0;
    localparam logic [MSG_W-1:0] MSG_NEAREST    = 4'd1;
    localparam logic [MSG_W-1:0] MSG_PIXEL_REP  = 4'd2;
    localparam logic [MSG_W-1:0] MSG_DECIMATION = 4'd3;
    localparam logic [MSG_W-1:0] MSG_BLOCK_AVG  = 4'd4;
    localparam logic [MSG_W-1:0] MSG_ERR_NO_SEL = 4'd5;
    localparam logic [MSG_W-1:0] MSG_ERR_MULTI  = 4'd6;
    localparam logic [MSG_W-1:0] MSG_ERR_ZOOM   = 4'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SHOW  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/display_msg_arbiter_prio_pick.sv
// Fixed-priority encoder: the lowest set index of req_i wins.
module prio_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        // Walk from the top so the lowest index is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
                idx_o       = IDX_W'(i);
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_msg_arbiter.sv
// Fixed-priority owner of the scrolling HEX display with minimum dwell, sticky
// one-shot notices and preemption by higher-priority sources.
module display_msg_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MSG_W     = display_pkg::MSG_W,
    parameter int MIN_DWELL = 75_000_000,
    parameter int DWELL_W   = 27,
    parameter int IDLE_MSG  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       oneshot,
    input  logic [NUM_REQ*MSG_W-1:0] req_msg,
    input  logic                     scroll_done,
    output logic [MSG_W-1:0]         msg_id,
    output logic                     msg_valid,
    output logic                     restart,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy
);
    import display_pkg::*;

    localparam int                 IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(MIN_DWELL);
    localparam logic [MSG_W-1:0]   IDLE_ID   = MSG_W'(IDLE_MSG);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   owner_q;
    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic [DWELL_W-1:0] dwell_q;
    logic               pass_seen_q;
    logic [MSG_W-1:0]   msg_id_q;
    logic               msg_valid_q;
    logic               restart_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               busy_q;

    logic [NUM_REQ-1:0] eff, hi_mask;
    logic [NUM_REQ-1:0] win_oh, pre_oh, sel_oh;
    logic [IDX_W-1:0]   win_idx, pre_idx, sel_idx;
    logic               win_vld, pre_vld;
    logic [MSG_W-1:0]   owner_msg, sel_msg;
    logic               owner_eff, dwell_met, pend_clr, collide;
    logic               release_ok, take_grant, release_idle, msg_chg;

    assign eff = req | pend_q;

    prio_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_win (
        .req_i    (eff),
        .onehot_o (win_oh),
        .idx_o    (win_idx),
        .valid_o  (win_vld)
    );

    // Only requesters strictly above the owner in priority may preempt it.
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_mask[i] = (i < int'(owner_q));
        end
    end

    prio_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pre (
        .req_i    (eff & hi_mask),
        .onehot_o (pre_oh),
        .idx_o    (pre_idx),
        .valid_o  (pre_vld)
    );

    always_comb begin
        owner_msg    = req_msg[int'(owner_q)*MSG_W +: MSG_W];
        owner_eff    = eff[owner_q];
        dwell_met    = (dwell_q == DWELL_MAX);
        pend_clr     = (state_q == SHOW) && pend_q[owner_q] && pass_seen_q && dwell_met;
        collide      = pend_clr && oneshot[owner_q];
        release_ok   = (state_q == SHOW) && !owner_eff && dwell_met;
        take_grant   = ((state_q == IDLE) && win_vld)
                    || ((state_q != IDLE) && pre_vld)
                    || (release_ok && win_vld);
        release_idle = release_ok && !win_vld;
        msg_chg      = (owner_msg != msg_id_q);

        if ((state_q != IDLE) && pre_vld) begin
            sel_oh  = pre_oh;
            sel_idx = pre_idx;
        end else begin
            sel_oh  = win_oh;
            sel_idx = win_idx;
        end
        sel_msg = req_msg[int'(sel_idx)*MSG_W +: MSG_W];

        // A oneshot on the same cycle as the clear re-arms the pending bit.
        pend_d = pend_q;
        if (pend_clr) begin
            pend_d[owner_q] = 1'b0;
        end
        pend_d = pend_d | oneshot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            pend_q      <= '0;
            dwell_q     <= '0;
            pass_seen_q <= 1'b0;
            msg_id_q    <= IDLE_ID;
            msg_valid_q <= 1'b0;
            restart_q   <= 1'b0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            busy_q    <= |(req | pend_d);
            restart_q <= 1'b0;
            if (take_grant) begin
                state_q     <= GRANT;
                owner_q     <= sel_idx;
                grant_q     <= sel_oh;
                msg_id_q    <= sel_msg;
                msg_valid_q <= 1'b1;
                restart_q   <= 1'b1;
                dwell_q     <= '0;
                pass_seen_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE:  state_q <= IDLE;
                    GRANT: state_q <= SHOW;
                    SHOW: begin
                        if (release_idle) begin
                            state_q     <= IDLE;
                            grant_q     <= '0;
                            msg_id_q    <= IDLE_ID;
                            msg_valid_q <= 1'b0;
                            restart_q   <= 1'b1;
                        end else if (msg_chg) begin
                            msg_id_q    <= owner_msg;
                            restart_q   <= 1'b1;
                            dwell_q     <= '0;
                            pass_seen_q <= 1'b0;
                        end else begin
                            if (!dwell_met) begin
                                dwell_q <= dwell_q + 1'b1;
                            end
                            if (collide) begin
                                pass_seen_q <= 1'b0;
                            end else if (scroll_done) begin
                                pass_seen_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign msg_id    = msg_id_q;
    assign msg_valid = msg_valid_q;
    assign restart   = restart_q;
    assign grant     = grant_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_display_msg_arbiter.sv
// Directed bench for display_msg_arbiter with a short dwell of 8 cycles.
module tb_display_msg_arbiter;
    import display_pkg::*;

    localparam int NR = 4;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] oneshot = '0;
    logic [NR*MW-1:0] req_msg = '0;
    logic          scroll_done = 1'b0;
    logic [MW-1:0] msg_id;
    logic          msg_valid;
    logic          restart;
    logic [NR-1:0] grant;
    logic          busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    display_msg_arbiter #(
        .NUM_REQ   (NR),
        .MSG_W     (MW),
        .MIN_DWELL (8),
        .DWELL_W   (4),
        .IDLE_MSG  (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .oneshot     (oneshot),
        .req_msg     (req_msg),
        .scroll_done (scroll_done),
        .msg_id      (msg_id),
        .msg_valid   (msg_valid),
        .restart     (restart),
        .grant       (grant),
        .busy        (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [NR-1:0] g, input logic [MW-1:0] id,
                              input logic vld, input logic rst);
        check_val({tag, "_grant"},   32'(grant),     32'(g));
        check_val({tag, "_msg_id"},  32'(msg_id),    32'(id));
        check_val({tag, "_valid"},   32'(msg_valid), 32'(vld));
        check_val({tag, "_restart"}, 32'(restart),   32'(rst));
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_msg(input int i, input logic [MW-1:0] m);
        req_msg[i*MW +: MW] = m;
    endtask

    initial begin
        // Reset state
        tick(3);
        check_outs("rst", 4'b0000, 4'd0, 1'b0, 1'b0);
        check_val("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        // Level request on index 0, dropped at once: held for the dwell then IDLE
        req = 4'b0001;
        set_msg(0, 4'd5);
        tick();
        check_outs("t1_grant", 4'b0001, 4'd5, 1'b1, 1'b1);
        check_val("t1_state_grant", 32'(dut.state_q), 32'(GRANT));
        check_val("t1_busy", 32'(busy), 32'd1);
        tick();
        check_val("t1_restart_once", 32'(restart), 32'd0);
        check_val("t1_state_show", 32'(dut.state_q), 32'(SHOW));
        req = 4'b0000;
        tick(7);
        check_outs("t1_dwell7", 4'b0001, 4'd5, 1'b1, 1'b0);
        tick();
        check_outs("t1_dwell8", 4'b0001, 4'd5, 1'b1, 1'b0);
        tick();
        check_outs("t1_idle", 4'b0000, 4'd0, 1'b0, 1'b1);
        tick();
        check_val("t1_idle_restart_off", 32'(restart), 32'd0);

        // Message change on owner 3, then early release at dwell 2
        set_msg(3, 4'd1);
        req = 4'b1000;
        tick();
        check_outs("t5_grant", 4'b1000, 4'd1, 1'b1, 1'b1);
        tick();
        set_msg(3, 4'd2);
        tick();
        check_outs("t5_change", 4'b1000, 4'd2, 1'b1, 1'b1);
        check_val("t5_dwell0", 32'(dut.dwell_q), 32'd0);
        tick(2);
        check_val("t4_dwell2", 32'(dut.dwell_q), 32'd2);
        req = 4'b0000;
        tick(6);
        check_outs("t4_held", 4'b1000, 4'd2, 1'b1, 1'b0);
        tick();
        check_outs("t4_idle", 4'b0000, 4'd0, 1'b0, 1'b1);
        check_val("t4_busy", 32'(busy), 32'd0);

        // Pending owner 2 preempted by index 0, then regains the display
        set_msg(2, 4'd4);
        oneshot = 4'b0100;
        tick();
        oneshot = 4'b0000;
        check_val("t2_busy_pend", 32'(busy), 32'd1);
        check_val("t2_not_yet", 32'(msg_valid), 32'd0);
        tick();
        check_outs("t2_grant2", 4'b0100, 4'd4, 1'b1, 1'b1);
        tick(4);
        check_val("t2_dwell3", 32'(dut.dwell_q), 32'd3);
        req = 4'b0001;
        set_msg(0, 4'd7);
        tick();
        check_outs("t2_preempt", 4'b0001, 4'd7, 1'b1, 1'b1);
        check_val("t2_pend2_kept", 32'(dut.pend_q[2]), 32'd1);
        req = 4'b0000;
        tick(9);
        check_outs("t2_owner0_dwell", 4'b0001, 4'd7, 1'b1, 1'b0);
        tick();
        check_outs("t2_back_to_2", 4'b0100, 4'd4, 1'b1, 1'b1);
        tick(3);

        // Reset in SHOW together with a oneshot
        check_val("t6_in_show", 32'(dut.state_q), 32'(SHOW));
        reset = 1'b1;
        oneshot = 4'b0100;
        tick();
        check_outs("t6_reset", 4'b0000, 4'd0, 1'b0, 1'b0);
        check_val("t6_pend", 32'(dut.pend_q), 32'd0);
        check_val("t6_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        oneshot = 4'b0000;
        tick();

        // One-shot notice held until dwell and a full pass have both happened
        set_msg(1, 4'd3);
        oneshot = 4'b0010;
        tick();
        oneshot = 4'b0000;
        check_val("t3_idle_wait", 32'(msg_valid), 32'd0);
        tick();
        check_outs("t3_grant", 4'b0010, 4'd3, 1'b1, 1'b1);
        scroll_done = 1'b1;
        tick();
        scroll_done = 1'b0;
        tick(10);
        check_outs("t3_held_no_pass", 4'b0010, 4'd3, 1'b1, 1'b0);
        check_val("t3_pend_held", 32'(dut.pend_q[1]), 32'd1);
        scroll_done = 1'b1;
        tick();
        scroll_done = 1'b0;
        check_val("t3_pend_before_clr", 32'(dut.pend_q[1]), 32'd1);
        tick();
        check_val("t3_pend_cleared", 32'(dut.pend_q[1]), 32'd0);
        check_outs("t3_last_show", 4'b0010, 4'd3, 1'b1, 1'b0);
        check_val("t3_busy_off", 32'(busy), 32'd0);
        tick();
        check_outs("t3_idle", 4'b0000, 4'd0, 1'b0, 1'b1);
        tick();
        check_val("t3_restart_off", 32'(restart), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
